// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch front end.
// Entry layout of the in-flight queue plus the PC step helper.
package fetch_pc_ctrl_pkg;

    localparam int N            = 32;
    localparam int ILEN         = 32;
    localparam int PQ_DEPTH_DEF = 4;

    typedef logic [N-1:0]    addr_t;
    typedef logic [ILEN-1:0] instr_t;

    localparam addr_t RESET_PC_DEF = '0;

    typedef struct packed {
        addr_t  pc;
        logic   pred_taken;
        addr_t  pred_target;
        instr_t instr;
    } fq_entry_t;

    // Sequential next PC, wraps modulo 2^N.
    function automatic addr_t pc_seq(addr_t pc);
        return pc + addr_t'(4);
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch front-end bus: bpu lookup, imem request/response,
// ID handshake and redirect. master = fetch_pc_ctrl side.
interface fetch_pc_ctrl_if;
    import fetch_pc_ctrl_pkg::*;

    addr_t  o_bp_pc;
    logic   i_bp_prediction;
    addr_t  i_bp_target;
    logic   o_imem_req;
    addr_t  o_imem_addr;
    logic   i_imem_gnt;
    logic   i_imem_rvalid;
    instr_t i_imem_rdata;
    logic   o_if_valid;
    addr_t  o_if_pc;
    instr_t o_if_instr;
    logic   o_if_pred_taken;
    addr_t  o_if_pred_target;
    logic   i_if_ready;
    logic   i_redirect;
    addr_t  i_redirect_pc;

    modport master (
        output o_bp_pc, o_imem_req, o_imem_addr,
        output o_if_valid, o_if_pc, o_if_instr,
        output o_if_pred_taken, o_if_pred_target,
        input  i_bp_prediction, i_bp_target,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  i_if_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_bp_pc, o_imem_req, o_imem_addr,
        input  o_if_valid, o_if_pc, o_if_instr,
        input  o_if_pred_taken, o_if_pred_target,
        output i_bp_prediction, i_bp_target,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output i_if_ready, i_redirect, i_redirect_pc
    );

endinterface

// File: rtl/fetch_pc_ctrl_fetch_queue.sv
// Circular in-flight buffer: entries allocated at issue, filled
// in order by memory responses, popped in order towards ID.
module fetch_pc_ctrl_fetch_queue
    import fetch_pc_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          alloc_i,
    input  addr_t         alloc_pc_i,
    input  logic          alloc_pred_i,
    input  addr_t         alloc_tgt_i,
    input  logic          fill_i,
    input  instr_t        fill_instr_i,
    input  logic          pop_i,
    output logic          head_valid_o,
    output fq_entry_t     head_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] pending_o
);

    fq_entry_t        ent_q [DEPTH];
    fq_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    aptr_q, aptr_d;
    logic [PW-1:0]    fptr_q, fptr_d;
    logic [PW-1:0]    hptr_q, hptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    filled_q, filled_d;

    // Next state: flush wins; otherwise alloc, fill and pop together.
    always_comb begin
        ent_d    = ent_q;
        vld_d    = vld_q;
        aptr_d   = aptr_q;
        fptr_d   = fptr_q;
        hptr_d   = hptr_q;
        count_d  = count_q;
        filled_d = filled_q;
        if (flush_i) begin
            vld_d    = '0;
            aptr_d   = '0;
            fptr_d   = '0;
            hptr_d   = '0;
            count_d  = '0;
            filled_d = '0;
        end else begin
            if (alloc_i) begin
                ent_d[aptr_q] = '{pc:          alloc_pc_i,
                                  pred_taken:  alloc_pred_i,
                                  pred_target: alloc_tgt_i,
                                  instr:       '0};
                vld_d[aptr_q] = 1'b0;
                aptr_d        = aptr_q + PW'(1);
            end
            if (fill_i) begin
                ent_d[fptr_q].instr = fill_instr_i;
                vld_d[fptr_q]       = 1'b1;
                fptr_d              = fptr_q + PW'(1);
            end
            if (pop_i) begin
                vld_d[hptr_q] = 1'b0;
                hptr_d        = hptr_q + PW'(1);
            end
            count_d  = count_q + CW'(alloc_i) - CW'(pop_i);
            filled_d = filled_q + CW'(fill_i) - CW'(pop_i);
        end
    end

    // Queue state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q    <= '0;
            aptr_q   <= '0;
            fptr_q   <= '0;
            hptr_q   <= '0;
            count_q  <= '0;
            filled_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            vld_q    <= vld_d;
            aptr_q   <= aptr_d;
            fptr_q   <= fptr_d;
            hptr_q   <= hptr_d;
            count_q  <= count_d;
            filled_q <= filled_d;
        end
    end

    assign head_valid_o = vld_q[hptr_q];
    assign head_o       = ent_q[hptr_q];
    assign count_o      = count_q;
    assign pending_o    = count_q - filled_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC control: next-PC selection, in-order imem issue,
// stale-response dropping on redirect, hand-off to ID.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF,
    parameter int    PQ_DEPTH = PQ_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_ctrl_if.master bus
);

    localparam int CW = $clog2(PQ_DEPTH + 1);

    addr_t         pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic [CW:0]   inflight;
    logic [CW:0]   owed;
    logic          req;
    logic          alloc;
    logic          drop_hit;
    logic          fill;
    logic          pop;
    logic          head_valid;
    fq_entry_t     head;

    // Slots in use: live entries plus responses still to be thrown away.
    assign inflight = {1'b0, count} + {1'b0, drop_q};
    assign owed     = {1'b0, pending} + {1'b0, drop_q};

    assign req = rst_n && !bus.i_redirect
              && (inflight < (CW+1)'(PQ_DEPTH));

    assign alloc    = req && bus.i_imem_gnt;
    assign drop_hit = bus.i_imem_rvalid && (drop_q != '0);
    assign fill     = bus.i_imem_rvalid && !drop_hit
                   && !bus.i_redirect;
    assign pop      = head_valid && bus.i_if_ready
                   && !bus.i_redirect;

    // Next fetch PC: redirect, else prediction on issue, else hold.
    always_comb begin
        pc_d = pc_q;
        if (bus.i_redirect) begin
            pc_d = bus.i_redirect_pc;
        end else if (alloc) begin
            pc_d = bus.i_bp_prediction ? bus.i_bp_target
                                       : pc_seq(pc_q);
        end
    end

    // Drop counter: reload with all owed responses on redirect.
    always_comb begin
        drop_d = drop_q;
        if (bus.i_redirect) begin
            if (bus.i_imem_rvalid && (owed != '0)) begin
                drop_d = CW'(owed - (CW+1)'(1));
            end else begin
                drop_d = CW'(owed);
            end
        end else if (drop_hit) begin
            drop_d = drop_q - CW'(1);
        end
    end

    // PC and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_pc_ctrl_fetch_queue #(
        .DEPTH (PQ_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (bus.i_redirect),
        .alloc_i      (alloc),
        .alloc_pc_i   (pc_q),
        .alloc_pred_i (bus.i_bp_prediction),
        .alloc_tgt_i  (bus.i_bp_target),
        .fill_i       (fill),
        .fill_instr_i (bus.i_imem_rdata),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (count),
        .pending_o    (pending)
    );

    assign bus.o_bp_pc          = pc_q;
    assign bus.o_imem_req       = req;
    assign bus.o_imem_addr      = pc_q;
    assign bus.o_if_valid       = head_valid;
    assign bus.o_if_pc          = head.pc;
    assign bus.o_if_instr       = head.instr;
    assign bus.o_if_pred_taken  = head.pred_taken;
    assign bus.o_if_pred_target = head.pred_target;

endmodule
